// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with look-ahead pixel requests and a LAT-deep sync/blank pipeline
module vga_timing_gen #(
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int COLOR_W = 4,
  parameter int LAT     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [10:0]        o_req_x,
  output logic [10:0]        o_req_y,
  output logic               o_req_valid,
  output logic               o_line_start,
  output logic               o_frame_start,
  input  logic [COLOR_W-1:0] i_red,
  input  logic [COLOR_W-1:0] i_green,
  input  logic [COLOR_W-1:0] i_blue,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B
);
  localparam int H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] HA  = 11'(H_ACT);
  localparam logic [10:0] HS0 = 11'(H_ACT + H_FRONT);
  localparam logic [10:0] HS1 = 11'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [10:0] HL  = 11'(H_TOTAL - 1);
  localparam logic [10:0] VA  = 11'(V_ACT);
  localparam logic [10:0] VS0 = 11'(V_ACT + V_FRONT);
  localparam logic [10:0] VS1 = 11'(V_ACT + V_FRONT + V_SYNC);
  localparam logic [10:0] VL  = 11'(V_TOTAL - 1);

  if (H_ACT == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_ACT == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_zero
    $error("vga_timing_gen: timing parameters must be nonzero");
  end
  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2047");
  end
  if (LAT < 0 || LAT > 7) begin : g_bad_lat
    $error("vga_timing_gen: LAT must be in 0..7");
  end

  logic [10:0] h_q, h_d, v_q, v_d;
  logic        hs_raw, vs_raw, act_raw;
  logic        hs_p, vs_p, act_p;

  always_comb begin
    h_d           = (h_q == HL) ? '0 : h_q + 11'd1;
    v_d           = (h_q != HL) ? v_q : (v_q == VL) ? '0 : v_q + 11'd1;
    act_raw       = (h_q < HA) && (v_q < VA);
    hs_raw        = (h_q >= HS0) && (h_q < HS1);
    vs_raw        = (v_q >= VS0) && (v_q < VS1);
    o_req_x       = (h_q < HA) ? h_q : '0;
    o_req_y       = (v_q < VA) ? v_q : '0;
    o_req_valid   = act_raw && !i_rst;
    o_line_start  = o_req_valid && (h_q == '0);
    o_frame_start = o_line_start && (v_q == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Sync and blanking travel alongside the fetch so they meet the returned pixel
  if (LAT == 0) begin : g_nodly
    assign {hs_p, vs_p, act_p} = {hs_raw, vs_raw, act_raw};
  end else begin : g_dly
    logic [2:0] dly_q [LAT];
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= {hs_raw, vs_raw, act_raw};
        for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign {hs_p, vs_p, act_p} = dly_q[LAT-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      oVGA_HS <= ~HS_POL;
      oVGA_VS <= ~VS_POL;
      oVGA_R  <= '0;
      oVGA_G  <= '0;
      oVGA_B  <= '0;
    end else begin
      oVGA_HS <= hs_p ? HS_POL : ~HS_POL;
      oVGA_VS <= vs_p ? VS_POL : ~VS_POL;
      oVGA_R  <= act_p ? i_red : '0;
      oVGA_G  <= act_p ? i_green : '0;
      oVGA_B  <= act_p ? i_blue : '0;
    end
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised single-clock VGA timing generator. It replaces the fixed 640x480 controller in the framebuffer path. Every line and frame timing value and both sync polarities are parameters. The block issues pixel-coordinate requests a configurable number of cycles ahead of the display, so the SDRAM/line-buffer fetch path has a known latency budget. Sync, blanking and colour leave the block aligned on the same output register stage.

## Interface
- H_ACT, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACT, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of oVGA_HS (0 = active-low)
- VS_POL, 0, asserted level of oVGA_VS
- COLOR_W, 4, bits per colour channel
- LAT, 2, cycles from request to valid i_red/i_green/i_blue; legal range 0..7
- i_clk  in  1  pixel clock; the only clock in the block
- i_rst  in  1  synchronous, active-high reset
- o_req_x  out  11  column of the requested pixel
- o_req_y  out  11  row of the requested pixel
- o_req_valid  out  1  request is for an active pixel
- o_line_start  out  1  one-cycle pulse: request for x=0 of an active line
- o_frame_start  out  1  one-cycle pulse: request for (0,0)
- i_red, i_green, i_blue  in  COLOR_W each  pixel data; presented exactly LAT cycles after its request
- oVGA_HS, oVGA_VS  out  1 each  registered syncs
- oVGA_R, oVGA_G, oVGA_B  out  COLOR_W each  registered colour; zero when blanked

## Operation
- Totals: H_TOTAL = H_ACT+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_ACT+V_FRONT+V_SYNC+V_BACK.
- Line order: active, front porch, sync, back porch. Frame order uses the same sequence in lines.
- Counter h_cnt (11 bits) runs 0..H_TOTAL-1 and wraps to 0.
- Counter v_cnt (11 bits) increments only on the cycle where h_cnt wraps. It runs 0..V_TOTAL-1 and wraps to 0.
- A single always-block domain. No derived or ripple clocks.
- Request position is a pure function of the counters:
  - o_req_x = h_cnt when h_cnt < H_ACT, else 0
  - o_req_y = v_cnt when v_cnt < V_ACT, else 0
- o_req_valid = (h_cnt < H_ACT) && (v_cnt < V_ACT) && !i_rst.
- o_line_start = o_req_valid && h_cnt == 0.
- o_frame_start = o_line_start && v_cnt == 0.
- Raw sync terms, computed from the counters:
  - hs_raw is asserted for H_ACT+H_FRONT <= h_cnt < H_ACT+H_FRONT+H_SYNC.
  - vs_raw is asserted for V_ACT+V_FRONT <= v_cnt < V_ACT+V_FRONT+V_SYNC, for the whole of each such line.
- A delay line of LAT flops carries {hs_raw, vs_raw, active}.
  - With LAT=0 the delay line is a wire.
  - The delayed terms feed the output register.
- Output register, every cycle:
  - oVGA_HS <= hs_d ? HS_POL : ~HS_POL
  - oVGA_VS <= vs_d ? VS_POL : ~VS_POL
  - colour <= active_d ? i_* : 0
- Reset (i_rst high at a clock edge):
  - h_cnt and v_cnt go to 0.
  - All delay flops go to inactive.
  - oVGA_HS = ~HS_POL and oVGA_VS = ~VS_POL.
  - Colours go to 0.
  - o_req_valid, o_line_start and o_frame_start are 0 while i_rst is high.
- Reset mid-frame: the frame is abandoned immediately. The first request after release is (0,0) with o_frame_start=1.
- Parameter checks at elaboration: error if any timing parameter is 0, if H_TOTAL > 2047 or V_TOTAL > 2047, or if LAT > 7.

## Timing
- First cycle after i_rst falls: request (0,0), o_req_valid=1, o_frame_start=1.
- Pipeline depth: a request at edge t reaches the pins on edge t+LAT+1.
  - Applies identically to the syncs, the blanking decision and the colour for that position.
  - i_* are sampled at edge t+LAT.
- Line period is H_TOTAL cycles. Frame period is H_TOTAL*V_TOTAL cycles.
- On the last cycle of a frame, h_cnt and v_cnt wrap on the same edge. The next request is (0,0) with no gap cycle.
- i_* are ignored (colour forced to 0) whenever the delayed active flag is 0. This holds even if the source drives nonzero data.

## Test plan
- Reset release, defaults, LAT=2:
  - o_frame_start pulses on the first cycle.
  - o_req_valid stays high for 640 cycles, then low for 160.
  - o_line_start recurs every 800 cycles.
- HS timing, defaults:
  - Per line, oVGA_HS is low for exactly 96 cycles.
  - The falling edge occurs 656+LAT+1 = 659 cycles after the o_line_start cycle.
- VS timing, defaults:
  - oVGA_VS is low for exactly 2*800 = 1600 cycles per frame.
  - Frame period is 800*525 = 420000 cycles, checked across 2 frames.
- Latency alignment, LAT=0 and LAT=5 runs:
  - The source drives i_red = o_req_x[3:0], delayed LAT cycles.
  - oVGA_R equals x[3:0] for each active pixel and 0 in blanking, including at x=639 and x=0.
- Polarity/size variant, H_ACT=800/40/128/88, V_ACT=600/1/4/23, HS_POL=VS_POL=1:
  - HS is high for 128 cycles per 1056-cycle line.
  - VS is high for 4 lines per 628-line frame.
- Mid-frame reset:
  - Assert i_rst for 3 cycles at (x=300, y=200).
  - During reset: outputs at reset values and o_req_valid=0.
  - After release: request (0,0) with o_frame_start=1. Syncs and colour stay deasserted/zero until the pipeline refills.
